vdp_super_res_prefetch: RTL
===========================

Name: vdp_super_res_prefetch

Overview:
- Sits directly upstream of the super-resolution renderer.
- Turns the renderer's line-start address plus its word-consume strobes into sequential 32-bit VRAM read requests to the memory arbiter.
- Buffers returned words in a small FIFO and presents the head word on vrm_32, so renderer timing tolerates variable SDRAM read latency.

Parameters:
- DEPTH, 4, FIFO entries of 32 bits; power of two, minimum 2.
- MAX_OUTSTANDING, 2, maximum reads issued but not yet returned; must be ≤ DEPTH.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- vdp_super  in  1  super modes enabled; 0 holds the block in its reset state (synchronous clear)
- line_start  in  1  one-cycle pulse: flush and restart fetching at start_addr
- start_addr  in  18  VRAM 32-bit word address for the first word of the line
- super_res_drawing  in  1  bus owned by renderer; requests are issued only while high
- pop  in  1  renderer has consumed the head word
- vrm_32  out  32  head FIFO word (0 when empty)
- vrm_valid  out  1  FIFO non-empty
- mem_rd_req  out  1  read request, held until mem_ack
- mem_addr  out  18  read word address
- mem_ack  in  1  request accepted this cycle
- mem_rd_valid  in  1  read data strobe; returns are in order
- mem_rd_data  in  32  read data
- underrun  out  1  sticky: pop while empty; cleared by line_start

Behaviour:
- Reset (reset_n low, or vdp_super low):
  - vrm_32=0, vrm_valid=0, mem_rd_req=0, mem_addr=0, underrun=0.
  - FIFO pointers, fetch address, outstanding count and discard count are all 0.
- Arbitrary clk-relative assertion of reset_n is legal. Outputs go low asynchronously.
- FIFO: DEPTH entries with write/read pointers one bit wider than log2(DEPTH). Full when the MSBs differ and the low bits match; empty when the pointers are equal.
- Issue rule: assert mem_rd_req only when all of the following hold:
  - super_res_drawing=1;
  - occupancy + outstanding < DEPTH (credit: every issued read is guaranteed FIFO space);
  - outstanding < MAX_OUTSTANDING.
- mem_addr holds the fetch address while mem_rd_req is high.
- On mem_ack with mem_rd_req high: fetch address +1 (wraps 3FFFF→0), outstanding +1.
- mem_rd_req may deassert without an ack if super_res_drawing falls. A request is never dropped once acked.
- Return: mem_rd_valid writes mem_rd_data to the FIFO and decrements outstanding. Simultaneous ack and valid leave outstanding unchanged.
- Pop: pop with vrm_valid=1 advances the read pointer. vrm_32 shows the new head on the next cycle (registered head, 1-cycle pop-to-data latency).
- Push into an empty FIFO makes vrm_valid=1 on the next cycle.
- Simultaneous push and pop on a non-empty FIFO: occupancy unchanged.
- Pop on an empty FIFO: ignored, underrun <= 1.
- line_start flush (takes priority over same-cycle pop and push):
  - FIFO emptied, vrm_valid=0, fetch address <= start_addr, underrun <= 0, mem_rd_req deasserted for that cycle.
  - Reads still outstanding at flush are counted into a discard counter. Their returns are dropped and do not enter the FIFO.
  - New requests may issue from the next cycle, subject to the credit rule, which counts the discards as outstanding.
- State machine: IDLE (no drawing) / FETCH (issuing) / WAIT (credit exhausted).
  - IDLE→FETCH on super_res_drawing with credit available.
  - FETCH→WAIT when credit is exhausted.
  - WAIT→FETCH on a pop or return that restores credit.
  - Any state→IDLE on super_res_drawing=0 with no request pending ack.
  - line_start→FETCH if super_res_drawing=1, else IDLE.

Optional Feature:
- Macro: VDP_PREFETCH_STATS_EN.
- With it defined: adds output underrun_count[15:0], which counts underrun events.
  - Saturates at FFFF.
  - Cleared only by reset, not by line_start.
- Without it: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package vdp_super_pkg:
  - typedef vram_word_addr_t (18-bit) and vram_word_t (32-bit);
  - constant VRAM_WORD_ADDR_MAX = 18'h3FFFF;
  - enum prefetch_state_t {IDLE, FETCH, WAIT}.
- One sub-module: vdp_prefetch_fifo. It is a parameterised synchronous FIFO with flush, count output and registered head; the controller instantiates it.

Test Plan:
- Reset mid-fetch: with 2 reads outstanding, pulse reset_n low → all outputs 0. Returns arriving after release are ignored; first request goes to start_addr after the next line_start.
- Zero-latency memory (ack same cycle, data 1 cycle later), line_start start_addr=18'h00100, pop every cycle → mem_addr sequence 100,101,102…; vrm_32 matches the data for those addresses in order; underrun stays 0.
- Backpressure: no pops, DEPTH=4 → exactly 4 requests acked, then mem_rd_req=0 and state WAIT. One pop → exactly one further request.
- Flush with in-flight reads: 2 outstanding, then line_start with start_addr=18'h02000 → both late returns discarded; first FIFO word is the data for 02000.
- Wrap: start_addr=18'h3FFFE → addresses 3FFFE,3FFFF,00000.
- Underrun: pop with FIFO empty → underrun=1 (and underrun_count=1 with VDP_PREFETCH_STATS_EN). line_start clears underrun, not underrun_count.

Source files
------------

// File: rtl/vdp_super_pkg.sv
// Shared types and constants for the super-resolution VRAM prefetch path.
package vdp_super_pkg;

    typedef logic [17:0] vram_word_addr_t;
    typedef logic [31:0] vram_word_t;

    localparam vram_word_addr_t VRAM_WORD_ADDR_MAX = 18'h3FFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2
    } prefetch_state_t;

    // Sequential word address with explicit wrap at the top of VRAM.
    function automatic vram_word_addr_t next_word_addr(input vram_word_addr_t addr);
        return (addr == VRAM_WORD_ADDR_MAX) ? '0 : addr + 18'd1;
    endfunction

endpackage

// File: rtl/vdp_prefetch_fifo.sv
// Small synchronous FIFO with flush, occupancy count and a registered head word
// (head is 0 whenever the FIFO is empty).
module vdp_prefetch_fifo
    import vdp_super_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clear,
    input  logic       push,
    input  vram_word_t push_data,
    input  logic       pop,
    output vram_word_t head,
    output logic       valid,
    output logic [AW:0] count
);

    logic [AW:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
    vram_word_t  mem [DEPTH];
    vram_word_t  head_n;
    logic        empty, full, do_push, do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign wr_ptr_n = wr_ptr + (AW+1)'(do_push);
    assign rd_ptr_n = rd_ptr + (AW+1)'(do_pop);

    // The next head may be the word being written this very cycle, so bypass it.
    always_comb begin
        head_n = mem[rd_ptr_n[AW-1:0]];
        if (wr_ptr_n == rd_ptr_n) begin
            head_n = '0;
        end else if (do_push && (rd_ptr_n[AW-1:0] == wr_ptr[AW-1:0])) begin
            head_n = push_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            head   <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            head   <= '0;
        end else begin
            wr_ptr <= wr_ptr_n;
            rd_ptr <= rd_ptr_n;
            head   <= head_n;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    assign valid = !empty;
    assign count = wr_ptr - rd_ptr;

endmodule

// File: rtl/vdp_super_res_prefetch.sv
// VRAM word prefetcher for the super-resolution renderer: credit-limited sequential
// reads into a small FIFO. VDP_PREFETCH_STATS_EN adds a saturating underrun_count output.
//
// state | meaning
// IDLE  | renderer does not own the bus, no requests
// FETCH | issuing sequential reads while credit allows
// WAIT  | credit exhausted, waiting for a pop or a return
module vdp_super_res_prefetch
    import vdp_super_pkg::*;
#(
    parameter int DEPTH           = 4,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            vdp_super,
    input  logic            line_start,
    input  vram_word_addr_t start_addr,
    input  logic            super_res_drawing,
    input  logic            pop,
    output vram_word_t      vrm_32,
    output logic            vrm_valid,
    output logic            mem_rd_req,
    output vram_word_addr_t mem_addr,
    input  logic            mem_ack,
    input  logic            mem_rd_valid,
    input  vram_word_t      mem_rd_data,
    output logic            underrun
`ifdef VDP_PREFETCH_STATS_EN
    ,
    output logic [15:0]     underrun_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = CW + 2;

    prefetch_state_t state, state_n;
    vram_word_addr_t fetch_addr;
    logic [CW-1:0]   outstanding, outstanding_n;
    logic [CW-1:0]   discard, discard_n;
    logic [AW:0]     fifo_count, fifo_count_n;
    logic            fifo_valid;

    logic clear, ack_fire, ret_discard, ret_live;
    logic fifo_push, fifo_pop, pop_empty;
    logic credit_now, credit_next;

    assign clear       = line_start || !vdp_super;
    assign ack_fire    = mem_rd_req && mem_ack;
    assign ret_discard = mem_rd_valid && (discard != '0);
    // Returns with nothing in flight (e.g. after a reset) are dropped.
    assign ret_live    = mem_rd_valid && (discard == '0) && (outstanding != '0);
    assign fifo_push   = ret_live && !clear;
    assign fifo_pop    = pop && fifo_valid && !clear;
    assign pop_empty   = pop && !fifo_valid && vdp_super && !line_start;

    // Discarded reads still occupy credit until their data comes back.
    assign credit_now =
        ((SW'(fifo_count) + SW'(outstanding) + SW'(discard)) < SW'(DEPTH)) &&
        ((SW'(outstanding) + SW'(discard)) < SW'(MAX_OUTSTANDING));

    assign mem_rd_req = reset_n && vdp_super && super_res_drawing && !line_start && credit_now;
    assign mem_addr   = fetch_addr;

    always_comb begin
        outstanding_n = outstanding;
        discard_n     = discard;
        if (line_start) begin
            discard_n     = discard + outstanding - CW'(ret_discard || ret_live);
            outstanding_n = '0;
        end else begin
            if (ret_discard) begin
                discard_n = discard - CW'(1);
            end
            outstanding_n = outstanding + CW'(ack_fire) - CW'(ret_live);
        end
    end

    assign fifo_count_n = clear ? '0 : fifo_count + (AW+1)'(fifo_push) - (AW+1)'(fifo_pop);

    assign credit_next =
        ((SW'(fifo_count_n) + SW'(outstanding_n) + SW'(discard_n)) < SW'(DEPTH)) &&
        ((SW'(outstanding_n) + SW'(discard_n)) < SW'(MAX_OUTSTANDING));

    always_comb begin
        state_n = state;
        if (line_start) begin
            state_n = super_res_drawing ? FETCH : IDLE;
        end else if (!super_res_drawing) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE:    state_n = credit_now  ? FETCH : IDLE;
                FETCH:   state_n = credit_next ? FETCH : WAIT;
                WAIT:    state_n = credit_next ? FETCH : WAIT;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            fetch_addr  <= '0;
            outstanding <= '0;
            discard     <= '0;
            underrun    <= 1'b0;
        end else if (!vdp_super) begin
            state       <= IDLE;
            fetch_addr  <= '0;
            outstanding <= '0;
            discard     <= '0;
            underrun    <= 1'b0;
        end else begin
            state       <= state_n;
            outstanding <= outstanding_n;
            discard     <= discard_n;
            if (line_start) begin
                fetch_addr <= start_addr;
                underrun   <= 1'b0;
            end else begin
                if (ack_fire) begin
                    fetch_addr <= next_word_addr(fetch_addr);
                end
                if (pop_empty) begin
                    underrun <= 1'b1;
                end
            end
        end
    end

`ifdef VDP_PREFETCH_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            underrun_count <= '0;
        end else if (!vdp_super) begin
            underrun_count <= '0;
        end else if (pop_empty && (underrun_count != 16'hFFFF)) begin
            underrun_count <= underrun_count + 16'd1;
        end
    end
`endif

    vdp_prefetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (clear),
        .push      (fifo_push),
        .push_data (mem_rd_data),
        .pop       (fifo_pop),
        .head      (vrm_32),
        .valid     (fifo_valid),
        .count     (fifo_count)
    );

    assign vrm_valid = fifo_valid;

endmodule
